// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch/address stage.
//   JMP_*      : jmp_mux encodings for the PC next-value select
//   CPU_ADDR_W : default address width (PC, MR, memory address)
//   CPU_DATA_W : default data width (memory data, IR)
package cpu_pkg;

  localparam logic [1:0] JMP_INC  = 2'b00;  // PC + 1
  localparam logic [1:0] JMP_ABS  = 2'b01;  // absolute target from memory
  localparam logic [1:0] JMP_RELN = 2'b10;  // PC - mag
  localparam logic [1:0] JMP_RELP = 2'b11;  // PC + mag

  localparam int unsigned CPU_ADDR_W = 8;
  localparam int unsigned CPU_DATA_W = 8;

endpackage

// File: rtl/pc_next_gen.sv
// Combinational next-PC generator.
//   pc        : current program counter
//   jmp_mux   : next-value select (JMP_* encodings)
//   instr_lo  : IR[2:0], relative jump magnitude
//   mem_rdata : memory read data, low ADDR_W bits (absolute target)
//   next_pc   : candidate PC, modulo 2^ADDR_W
module pc_next_gen
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = CPU_ADDR_W
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [1:0]        jmp_mux,
  input  logic [2:0]        instr_lo,
  input  logic [ADDR_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] mag;

  always_comb begin
    mag       = '0;
    mag[2:0]  = instr_lo;
    unique case (jmp_mux)
      JMP_INC:  next_pc = pc + ADDR_W'(1);
      JMP_ABS:  next_pc = mem_rdata;
      JMP_RELN: next_pc = pc - mag;
      JMP_RELP: next_pc = pc + mag;
      default:  next_pc = pc;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch and address stage: PC, IR, MR, retired-instruction
// counter and PC breakpoint flag. Sequenced by the controller strobes.
//   clk, reset      : rising-edge clock, async active-low reset
//   ir_load/mr_load : load IR / MR from mem_rdata
//   pc_load/jmp_mux : update PC with the selected next value
//   mem_inst        : memory address select (1 = PC, 0 = MR)
//   mem_rdata       : memory read data (combinational on mem_addr)
//   bp_en/bp_addr   : breakpoint enable and PC match value
//   mem_addr        : memory address (combinational)
//   instr, pc, mr   : IR, PC, MR contents
//   instr_count     : IR loads since reset (wrapping)
//   bp_hit          : one-cycle pulse after PC is loaded with bp_addr
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned           ADDR_W   = CPU_ADDR_W,
  parameter int unsigned           DATA_W   = CPU_DATA_W,
  parameter logic [ADDR_W-1:0]     RESET_PC = '0,
  parameter int unsigned           CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ir_load,
  input  logic              mr_load,
  input  logic              pc_load,
  input  logic [1:0]        jmp_mux,
  input  logic              mem_inst,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] mr,
  output logic [CNT_W-1:0]  instr_count,
  output logic              bp_hit
);

  logic [ADDR_W-1:0] pc_q, pc_d, next_pc;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0] mr_q, mr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              bp_hit_q, bp_hit_d;

  pc_next_gen #(
    .ADDR_W (ADDR_W)
  ) u_pc_next_gen (
    .pc        (pc_q),
    .jmp_mux   (jmp_mux),
    .instr_lo  (ir_q[2:0]),
    .mem_rdata (mem_rdata[ADDR_W-1:0]),
    .next_pc   (next_pc)
  );

  always_comb begin
    pc_d     = pc_q;
    ir_d     = ir_q;
    mr_d     = mr_q;
    cnt_d    = cnt_q;
    // Match is taken on the value being loaded, so a PC that merely
    // sits on bp_addr never re-triggers.
    bp_hit_d = pc_load && bp_en && (next_pc == bp_addr);
    if (pc_load) pc_d = next_pc;
    if (ir_load) begin
      ir_d  = mem_rdata;
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (mr_load) mr_d = mem_rdata[ADDR_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      mr_q     <= '0;
      cnt_q    <= '0;
      bp_hit_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      mr_q     <= mr_d;
      cnt_q    <= cnt_d;
      bp_hit_q <= bp_hit_d;
    end
  end

  assign mem_addr    = mem_inst ? pc_q : mr_q;
  assign instr       = ir_q;
  assign pc          = pc_q;
  assign mr          = mr_q;
  assign instr_count = cnt_q;
  assign bp_hit      = bp_hit_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        ir_load, mr_load, pc_load, mem_inst, bp_en;
  logic [1:0]  jmp_mux;
  logic [7:0]  mem_rdata, bp_addr;
  logic [7:0]  mem_addr, instr, pc, mr;
  logic [15:0] instr_count;
  logic        bp_hit;

  int checks = 0;
  int errors = 0;

  fetch_unit #(
    .ADDR_W   (8),
    .DATA_W   (8),
    .RESET_PC (8'h00),
    .CNT_W    (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ir_load     (ir_load),
    .mr_load     (mr_load),
    .pc_load     (pc_load),
    .jmp_mux     (jmp_mux),
    .mem_inst    (mem_inst),
    .mem_rdata   (mem_rdata),
    .bp_en       (bp_en),
    .bp_addr     (bp_addr),
    .mem_addr    (mem_addr),
    .instr       (instr),
    .pc          (pc),
    .mr          (mr),
    .instr_count (instr_count),
    .bp_hit      (bp_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobes(input logic ir, input logic mrl, input logic pcl,
                         input logic [1:0] jm, input logic [7:0] rd);
    ir_load   = ir;
    mr_load   = mrl;
    pc_load   = pcl;
    jmp_mux   = jm;
    mem_rdata = rd;
  endtask

  initial begin
    reset    = 1'b0;
    mem_inst = 1'b1;
    bp_en    = 1'b0;
    bp_addr  = 8'h00;
    strobes(1'b1, 1'b1, 1'b1, 2'b00, 8'h5A);
    #20;
    check("rst_pc",    32'(pc),          32'h00);
    check("rst_instr", 32'(instr),       32'h00);
    check("rst_mr",    32'(mr),          32'h00);
    check("rst_cnt",   32'(instr_count), 32'h0);
    check("rst_bp",    32'(bp_hit),      32'h0);

    // Release, first fetch
    #1 reset = 1'b1;
    strobes(1'b1, 1'b0, 1'b1, 2'b00, 8'h5A);
    step();
    check("fetch_instr", 32'(instr),       32'h5A);
    check("fetch_pc",    32'(pc),          32'h01);
    check("fetch_cnt",   32'(instr_count), 32'h1);

    // Absolute jump to 0x10, then to 0x3C
    strobes(1'b0, 1'b0, 1'b1, 2'b01, 8'h10);
    step();
    check("abs_pc10",   32'(pc),       32'h10);
    check("abs_addr10", 32'(mem_addr), 32'h10);
    strobes(1'b0, 1'b0, 1'b1, 2'b01, 8'h3C);
    step();
    check("abs_pc3c",   32'(pc),    32'h3C);
    check("abs_ir_keep", 32'(instr), 32'h5A);

    // Relative +: pc 0x20, instr 0x65 -> 0x25
    strobes(1'b0, 1'b0, 1'b1, 2'b01, 8'h20);
    step();
    strobes(1'b1, 1'b0, 1'b0, 2'b00, 8'h65);
    step();
    check("ld65_instr", 32'(instr),       32'h65);
    check("ld65_pc",    32'(pc),          32'h20);
    check("ld65_cnt",   32'(instr_count), 32'h2);
    strobes(1'b0, 1'b0, 1'b1, 2'b11, 8'h00);
    step();
    check("relp_pc", 32'(pc), 32'h25);

    // Relative -: pc 0x20, instr 0x6D -> 0x1B
    strobes(1'b0, 1'b0, 1'b1, 2'b01, 8'h20);
    step();
    strobes(1'b1, 1'b0, 1'b0, 2'b00, 8'h6D);
    step();
    strobes(1'b0, 1'b0, 1'b1, 2'b10, 8'h00);
    step();
    check("reln_pc", 32'(pc), 32'h1B);

    // Relative - wrap: pc 0x02 - 5 -> 0xFD
    strobes(1'b0, 1'b0, 1'b1, 2'b01, 8'h02);
    step();
    strobes(1'b0, 1'b0, 1'b1, 2'b10, 8'h00);
    step();
    check("reln_wrap", 32'(pc), 32'hFD);

    // MR path
    strobes(1'b0, 1'b1, 1'b0, 2'b00, 8'h80);
    step();
    check("mr_load", 32'(mr), 32'h80);
    strobes(1'b0, 1'b0, 1'b0, 2'b00, 8'h00);
    mem_inst = 1'b0;
    #1;
    check("addr_mr", 32'(mem_addr), 32'h80);
    mem_inst = 1'b1;
    #1;
    check("addr_pc", 32'(mem_addr), 32'hFD);

    // IR and MR load together
    strobes(1'b1, 1'b1, 1'b0, 2'b00, 8'h44);
    step();
    check("both_instr", 32'(instr),       32'h44);
    check("both_mr",    32'(mr),          32'h44);
    check("both_cnt",   32'(instr_count), 32'h4);

    // Increment wrap and hold
    strobes(1'b0, 1'b0, 1'b1, 2'b01, 8'hFF);
    step();
    check("pc_ff", 32'(pc), 32'hFF);
    strobes(1'b0, 1'b0, 1'b1, 2'b00, 8'h00);
    step();
    check("inc_wrap", 32'(pc), 32'h00);
    strobes(1'b0, 1'b0, 1'b0, 2'b11, 8'h33);
    step();
    check("hold_pc", 32'(pc), 32'h00);

    // Breakpoint enabled: 05 -> 06 -> 07
    bp_en   = 1'b1;
    bp_addr = 8'h07;
    strobes(1'b0, 1'b0, 1'b1, 2'b01, 8'h05);
    step();
    check("bp_05", 32'(bp_hit), 32'h0);
    strobes(1'b0, 1'b0, 1'b1, 2'b00, 8'h00);
    step();
    check("bp_06", 32'(bp_hit), 32'h0);
    step();
    check("bp_07_pc",  32'(pc),     32'h07);
    check("bp_07_hit", 32'(bp_hit), 32'h1);
    pc_load = 1'b0;
    step();
    check("bp_held_nopulse", 32'(bp_hit), 32'h0);

    // Breakpoint disabled
    bp_en = 1'b0;
    strobes(1'b0, 1'b0, 1'b1, 2'b01, 8'h05);
    step();
    strobes(1'b0, 1'b0, 1'b1, 2'b00, 8'h00);
    step();
    step();
    check("bpdis_pc",  32'(pc),     32'h07);
    check("bpdis_hit", 32'(bp_hit), 32'h0);

    // Reset while bp_hit high clears immediately
    bp_en = 1'b1;
    strobes(1'b0, 1'b0, 1'b1, 2'b01, 8'h06);
    step();
    strobes(1'b0, 1'b0, 1'b1, 2'b00, 8'h00);
    step();
    check("bp_rearm_hit", 32'(bp_hit), 32'h1);
    reset = 1'b0;
    #1;
    check("async_bp",  32'(bp_hit),      32'h0);
    check("async_pc",  32'(pc),          32'h00);
    check("async_ir",  32'(instr),       32'h00);
    check("async_cnt", 32'(instr_count), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch and address stage directly upstream of the controller.
- Holds the program counter (PC), instruction register (IR) and memory-address register (MR).
- Drives the memory address and supplies the controller's `instr` input.
- Applies the controller's `IRload`/`MRload`/`PCload`/`JMPmux`/`MemInst` strobes; adds a retired-instruction counter and a PC breakpoint flag for debug.

Parameters:
- ADDR_W, 8, width of PC, MR and memory address.
- DATA_W, 8, width of memory data, IR and instr.
- RESET_PC, 0, PC value loaded on reset.
- CNT_W, 16, width of the instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- ir_load  in  1  load IR from mem_rdata.
- mr_load  in  1  load MR from mem_rdata.
- pc_load  in  1  update PC per jmp_mux.
- jmp_mux  in  2  PC next-value select.
- mem_inst  in  1  address select: 1 = PC, 0 = MR.
- mem_rdata  in  DATA_W  memory read data, combinational w.r.t. mem_addr.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  ADDR_W  breakpoint PC value.
- mem_addr  out  ADDR_W  memory address.
- instr  out  DATA_W  IR contents, fed to the controller.
- pc  out  ADDR_W  current PC.
- mr  out  ADDR_W  current MR.
- instr_count  out  CNT_W  number of IR loads since reset.
- bp_hit  out  1  one-cycle pulse: PC just became bp_addr.

Behaviour:
- Reset (reset = 0, asynchronous), outputs take these values:
  - pc = RESET_PC
  - instr = 0 (decodes as NOP)
  - mr = 0
  - instr_count = 0
  - bp_hit = 0
- Release is synchronous to clk via the standard reset synchroniser upstream.
- Reset asserted mid-instruction discards IR/MR/PC immediately. The first edge after release samples the strobes normally.
- mem_addr is combinational: mem_addr = mem_inst ? pc : mr. It carries no register and no latency.
- IR update: on a rising edge with ir_load = 1, IR <= mem_rdata (sampled at that edge).
- MR update: on a rising edge with mr_load = 1, MR <= mem_rdata[ADDR_W-1:0].
- ir_load and mr_load asserted together: both load the same mem_rdata.
- PC: on a rising edge with pc_load = 1, PC is updated by jmp_mux:
  - 00 = PC + 1.
  - 01 = mem_rdata[ADDR_W-1:0] (absolute jump target).
  - 10 = PC - mag.
  - 11 = PC + mag.
  - mag = {0, instr[2:0]}, zero-extended. Offsets apply to the current PC, which already points past the jump opcode.
  - All PC arithmetic is modulo 2^ADDR_W: 0xFF + 1 = 0x00; 0x02 - 5 = 0xFD.
- pc_load = 0: PC holds regardless of jmp_mux.
- Same-edge ordering: pc_load and ir_load on the same edge (fetch cycle) both take effect. IR captures mem_rdata at the old PC; PC becomes old PC + 1.
- instr_count increments by 1 on every edge with ir_load = 1. It wraps at 2^CNT_W - 1 to 0 without saturating.
- bp_hit: registered. It is 1 for exactly the cycle after an edge where pc_load = 1, bp_en = 1 and the new PC value equals bp_addr. Otherwise it is 0.
  - No pulse if PC already equalled bp_addr and was not reloaded.
  - No pulse if bp_en is low at the loading edge.
- There is no FSM. All state is the four registers plus bp_hit; the controller sequences them.

Decomposition:
- Shared package cpu_pkg holds:
  - JMP_INC = 2'b00, JMP_ABS = 2'b01, JMP_RELN = 2'b10, JMP_RELP = 2'b11.
  - ADDR_W and DATA_W defaults.
- One combinational sub-module, pc_next_gen: inputs pc, jmp_mux, instr[2:0], mem_rdata; output next_pc. fetch_unit instantiates it and registers the result.

Test Plan:
- Reset: hold reset = 0 with mem_rdata = 0x5A and all strobes = 1 -> pc = 0, instr = 0, mr = 0, instr_count = 0, bp_hit = 0. Release, then one edge with mem_inst = 1, ir_load = 1, pc_load = 1, jmp_mux = 00 -> instr = 0x5A, pc = 1, instr_count = 1.
- Absolute jump: pc = 0x10, mem_inst = 1, mem_addr = 0x10, mem_rdata = 0x3C, pc_load = 1, jmp_mux = 01 -> pc = 0x3C, IR unchanged.
- Relative jumps:
  - pc = 0x20, instr = 0x65, jmp_mux = 11 -> pc = 0x25.
  - instr = 0x6D, jmp_mux = 10 from pc = 0x20 -> pc = 0x1B.
  - pc = 0x02, instr = 0x6D, jmp_mux = 10 -> pc = 0xFD (wrap).
- MR path: mr_load = 1 with mem_rdata = 0x80 -> mr = 0x80. Next cycle mem_inst = 0 -> mem_addr = 0x80. With mem_inst = 1 -> mem_addr = pc.
- Wrap and hold: pc = 0xFF, pc_load = 1, jmp_mux = 00 -> pc = 0x00. pc_load = 0 with jmp_mux = 11 -> pc unchanged.
- Breakpoint: bp_en = 1, bp_addr = 0x07, pc stepping 0x05 -> 0x06 -> 0x07 -> bp_hit high exactly one cycle after the edge loading 0x07. Repeat with bp_en = 0 -> no pulse. Assert reset while bp_hit = 1 -> bp_hit = 0 immediately.
